// File: rtl/raw_forward_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : raw_forward_buffer_pkg
// Description : Shared types and helpers for the read-after-write forwarding
//               buffer. The burst size encoding is log2 of the byte count.
// Revision    : 1.0 - initial parametrised multi-entry release
// ============================================================================
package raw_forward_buffer_pkg;

    typedef enum logic [2:0] {
        ONE_BYTE      = 3'd0,
        TWO_BYTES     = 3'd1,
        FOUR_BYTES    = 3'd2,
        EIGHT_BYTES   = 3'd3,
        SIXTEEN_BYTES = 3'd4
    } burst_size_t;

    // Byte count of a burst; callers clamp to the data-path width.
    function automatic int unsigned burst_bytes(input burst_size_t size);
        return 32'd1 << size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/raw_forward_buffer_byte_rotator.sv
`default_nettype none
// ============================================================================
// Module      : raw_forward_buffer_byte_rotator
// Description : Byte-granular rotator with a per-byte validity mask that is
//               rotated along with the data, followed by an output byte select.
//               Bytes whose rotated mask or select bit is clear come out zero.
//               Right mode: out[j] = in[(j+amt) mod N] (line -> request order).
//               Left mode : out[j] = in[(j-amt) mod N] (request -> line lanes).
// Revision    : 1.0 - initial release
// ============================================================================
module raw_forward_buffer_byte_rotator #(
    parameter int NBYTES      = 8,
    parameter bit ROTATE_LEFT = 1'b0
) (
    input  logic [NBYTES*8-1:0]       i_data,
    input  logic [NBYTES-1:0]         i_mask,
    input  logic [NBYTES-1:0]         i_sel,
    input  logic [$clog2(NBYTES)-1:0] i_amount,
    output logic [NBYTES*8-1:0]       o_data,
    output logic [NBYTES-1:0]         o_mask
);

    localparam int c_COL_BITS = $clog2(NBYTES);

    // One output byte per iteration; the source index wraps modulo NBYTES
    // because NBYTES is a power of two and the index is c_COL_BITS wide.
    for (genvar j = 0; j < NBYTES; j++) begin : g_byte
        logic [c_COL_BITS-1:0] w_src;
        logic                  w_keep;

        assign w_src  = ROTATE_LEFT ? (c_COL_BITS'(j) - i_amount)
                                    : (c_COL_BITS'(j) + i_amount);
        assign w_keep = i_mask[w_src] & i_sel[j];

        assign o_mask[j]         = w_keep;
        assign o_data[j*8 +: 8]  = w_keep ? i_data[{w_src, 3'b000} +: 8] : 8'h00;
    end

endmodule
`default_nettype wire

// File: rtl/raw_forward_buffer.sv
`default_nettype none
// ============================================================================
// Module      : raw_forward_buffer
// Description : Tracks the DEPTH most recent write-pool lines as byte-masked
//               entries (coalescing same-line writes, FIFO replacement) and
//               answers read requests with rotated forwarded data, a byte
//               mask and a full-hit flag through a single response register.
// Revision    : 1.0 - initial parametrised multi-entry release
// ============================================================================
module raw_forward_buffer
    import raw_forward_buffer_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 64,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [ADDR_SIZE-1:0]       wr_addr,
    input  logic [DATA_SIZE-1:0]       wr_data,
    input  burst_size_t                wr_size,
    input  logic                       flush,
    input  logic                       rd_req_valid,
    output logic                       rd_req_ready,
    input  logic [ADDR_SIZE-1:0]       rd_addr,
    input  burst_size_t                rd_size,
    output logic                       rd_resp_valid,
    input  logic                       rd_resp_ready,
    output logic [DATA_SIZE-1:0]       rd_resp_data,
    output logic [DATA_SIZE/8-1:0]     rd_resp_mask,
    output logic                       rd_resp_hit,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int c_NBYTES    = DATA_SIZE / 8;
    localparam int c_COL_BITS  = $clog2(c_NBYTES);
    localparam int c_LINE_BITS = ADDR_SIZE - c_COL_BITS;
    localparam int c_OCC_BITS  = $clog2(DEPTH + 1);
    localparam int c_PTR_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic                   valid;
        logic [c_LINE_BITS-1:0] line;
        logic [c_NBYTES-1:0]    mask;
        logic [DATA_SIZE-1:0]   data;
    } raw_entry_t;

    // Low n byte-select bits for a burst, n clamped to the line width.
    function automatic logic [c_NBYTES-1:0] size_sel(input burst_size_t size);
        logic [c_NBYTES-1:0] sel;
        for (int unsigned i = 0; i < c_NBYTES; i++) begin
            sel[i] = (i < burst_bytes(size));
        end
        return sel;
    endfunction

    raw_entry_t             r_entries  [DEPTH];
    raw_entry_t             w_ent_next [DEPTH];
    logic [c_PTR_BITS-1:0]  r_wr_ptr;
    logic [c_PTR_BITS-1:0]  w_ptr_next;
    logic [c_OCC_BITS-1:0]  r_occ;
    logic [c_OCC_BITS-1:0]  w_occ_next;

    logic [c_LINE_BITS-1:0] w_wr_line;
    logic [c_COL_BITS-1:0]  w_wr_col;
    logic [c_NBYTES-1:0]    w_wr_sel;
    logic [DATA_SIZE-1:0]   w_wr_lane_data;
    logic [c_NBYTES-1:0]    w_wr_lane_mask;
    logic                   w_wr_hit;
    logic [c_PTR_BITS-1:0]  w_wr_idx;
    logic [c_PTR_BITS-1:0]  w_alloc_idx;
    logic                   w_alloc;

    logic [c_LINE_BITS-1:0] w_rd_line;
    logic [c_COL_BITS-1:0]  w_rd_col;
    logic [c_NBYTES-1:0]    w_rd_sel;
    logic                   w_rd_found;
    logic [DATA_SIZE-1:0]   w_rd_src_data;
    logic [c_NBYTES-1:0]    w_rd_src_mask;
    logic [DATA_SIZE-1:0]   w_rd_data;
    logic [c_NBYTES-1:0]    w_rd_mask;
    logic                   w_rd_hit;

    logic                   r_resp_valid;
    logic [DATA_SIZE-1:0]   r_resp_data;
    logic [c_NBYTES-1:0]    r_resp_mask;
    logic                   r_resp_hit;

    assign w_wr_line = wr_addr[ADDR_SIZE-1:c_COL_BITS];
    assign w_wr_col  = wr_addr[c_COL_BITS-1:0];
    assign w_wr_sel  = size_sel(wr_size);
    assign w_rd_line = rd_addr[ADDR_SIZE-1:c_COL_BITS];
    assign w_rd_col  = rd_addr[c_COL_BITS-1:0];
    assign w_rd_sel  = size_sel(rd_size);

    // Place write bytes onto their line lanes, wrapping inside the line.
    raw_forward_buffer_byte_rotator #(
        .NBYTES      (c_NBYTES),
        .ROTATE_LEFT (1'b1)
    ) u_wr_place (
        .i_data   (wr_data),
        .i_mask   (w_wr_sel),
        .i_sel    ({c_NBYTES{1'b1}}),
        .i_amount (w_wr_col),
        .o_data   (w_wr_lane_data),
        .o_mask   (w_wr_lane_mask)
    );

    // Next entry state: flush first, then coalesce or allocate the write.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_ent_next[e] = r_entries[e];
            if (flush) begin
                w_ent_next[e].valid = 1'b0;
            end
        end

        w_wr_hit = 1'b0;
        w_wr_idx = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (w_ent_next[e].valid && (w_ent_next[e].line == w_wr_line)) begin
                w_wr_hit = 1'b1;
                w_wr_idx = c_PTR_BITS'(e);
            end
        end

        // Entries fill in slot order after a flush, so the write pointer is
        // both the next free slot and, once full, the oldest entry.
        w_alloc_idx = flush ? '0 : r_wr_ptr;
        w_alloc     = wr_valid && !w_wr_hit;
        w_ptr_next  = w_alloc_idx;
        w_occ_next  = flush ? '0 : r_occ;

        if (wr_valid && w_wr_hit) begin
            for (int b = 0; b < c_NBYTES; b++) begin
                if (w_wr_lane_mask[b]) begin
                    w_ent_next[w_wr_idx].data[b*8 +: 8] = w_wr_lane_data[b*8 +: 8];
                end
            end
            w_ent_next[w_wr_idx].mask = w_ent_next[w_wr_idx].mask | w_wr_lane_mask;
        end else if (w_alloc) begin
            w_ent_next[w_alloc_idx] = '{valid: 1'b1, line: w_wr_line,
                                        mask: w_wr_lane_mask, data: w_wr_lane_data};
            w_ptr_next = (w_alloc_idx == c_PTR_BITS'(DEPTH - 1)) ? '0 : w_alloc_idx + 1'b1;
            if (w_occ_next < c_OCC_BITS'(DEPTH)) begin
                w_occ_next = w_occ_next + 1'b1;
            end
        end
    end

    // Read lookup sees the post-write state so a same-cycle write is visible.
    always_comb begin
        w_rd_found    = 1'b0;
        w_rd_src_data = '0;
        w_rd_src_mask = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (w_ent_next[e].valid && (w_ent_next[e].line == w_rd_line)) begin
                w_rd_found    = 1'b1;
                w_rd_src_data = w_ent_next[e].data;
                w_rd_src_mask = w_ent_next[e].mask;
            end
        end
    end

    // Bring the requested column down to byte 0 and keep only requested bytes.
    raw_forward_buffer_byte_rotator #(
        .NBYTES      (c_NBYTES),
        .ROTATE_LEFT (1'b0)
    ) u_rd_extract (
        .i_data   (w_rd_src_data),
        .i_mask   (w_rd_src_mask),
        .i_sel    (w_rd_sel),
        .i_amount (w_rd_col),
        .o_data   (w_rd_data),
        .o_mask   (w_rd_mask)
    );

    assign w_rd_hit = w_rd_found && (w_rd_mask == w_rd_sel);

    // Entry table, replacement pointer and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_entries[e] <= '0;
            end
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                r_entries[e] <= w_ent_next[e];
            end
            r_wr_ptr <= w_ptr_next;
            r_occ    <= w_occ_next;
        end
    end

    // Single response register; a held response ignores later writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_mask  <= '0;
            r_resp_hit   <= 1'b0;
        end else if (rd_req_ready) begin
            r_resp_valid <= rd_req_valid;
            if (rd_req_valid) begin
                r_resp_data <= w_rd_data;
                r_resp_mask <= w_rd_mask;
                r_resp_hit  <= w_rd_hit;
            end
        end
    end

    assign rd_req_ready  = !r_resp_valid || rd_resp_ready;
    assign rd_resp_valid = r_resp_valid;
    assign rd_resp_data  = r_resp_data;
    assign rd_resp_mask  = r_resp_mask;
    assign rd_resp_hit   = r_resp_hit;
    assign occupancy     = r_occ;

endmodule
`default_nettype wire

// File: doc/raw_forward_buffer.md
Name: raw_forward_buffer

Overview:
- Parametrised successor to the single-entry read-after-write forwarder between the write pool and the read path.
- Tracks the DEPTH most recent pool writes as line-aligned, byte-masked entries and coalesces writes to the same line.
- Serves read requests through a valid/ready handshake, returning byte-rotated data, a per-byte valid mask, and a full-hit flag.
- Sits beside the write pool; the read datapath uses the returned mask to merge forwarded bytes over DRAM data.

Parameters:
ADDR_SIZE, 8, byte address width
DATA_SIZE, 64, data width in bits; multiple of 8, byte count a power of two ≥2
DEPTH, 4, number of tracked lines (≥1)
(derived) NBYTES = DATA_SIZE/8; COL_BITS = log2(NBYTES); LINE = addr[ADDR_SIZE-1:COL_BITS]

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
wr_valid  in  1  pool write occurring this cycle
wr_addr  in  ADDR_SIZE  pool write byte address
wr_data  in  DATA_SIZE  write data, first byte in byte 0
wr_size  in  burst_size_t  write burst size
flush  in  1  invalidate all entries
rd_req_valid  in  1  read request valid
rd_req_ready  out  1  request accepted when valid&ready
rd_addr  in  ADDR_SIZE  read byte address
rd_size  in  burst_size_t  read burst size
rd_resp_valid  out  1  response valid
rd_resp_ready  in  1  consumer accepts response
rd_resp_data  out  DATA_SIZE  forwarded data, first requested byte in byte 0, unrequested bytes zero
rd_resp_mask  out  NBYTES  bit i = byte i forwarded
rd_resp_hit  out  1  every requested byte forwarded
occupancy  out  $clog2(DEPTH+1)  valid entry count

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- Reset (sync, active-high, mid-operation included): all entries invalid, occupancy 0, rd_resp_valid 0, rd_resp_data 0, rd_resp_mask 0, rd_resp_hit 0. Any in-flight response is dropped.
- Burst byte count: n = burst_bytes(size), clamped to NBYTES.
- Write lane placement: data byte i (i<n) goes to lane (col+i) mod NBYTES, where col = addr[COL_BITS-1:0]. Lanes wrap within the line; no spill into the next line.
- Write to a line already held: merge into that entry. New bytes overwrite, stored mask |= new mask, entry age unchanged, no allocation.
- Write to a new line, not full: allocate a free entry as youngest.
- Write to a new line, full (occupancy==DEPTH): overwrite the oldest entry (FIFO order). Occupancy stays DEPTH.
- flush: all entries invalid at the next edge. flush and wr_valid in the same cycle: flush first, then the write is allocated (occupancy 1).
- rd_req_ready = !rd_resp_valid || rd_resp_ready. This is a single response register with zero-bubble throughput.
- Read lookup, on accept:
  - Uses entry state including a same-cycle write: write-to-read bypass, merged bytes visible.
  - Matching entry's lane (col+i) mod NBYTES goes to result byte i for i<n.
  - mask bit i = stored mask bit of that lane, for i<n; bits ≥n are 0.
  - Unmasked bytes are 0.
  - hit = (mask == low n bits all ones).
  - No match: data 0, mask 0, hit 0.
- Latency: response registered at the edge where the request is accepted, so rd_resp_valid rises the next cycle.
- Response hold: rd_resp_* stay stable while rd_resp_valid && !rd_resp_ready. Later writes do not alter a held response.
- At most one entry matches a line at a time, guaranteed by coalescing.
- Occupancy: increments only on allocation into a free entry; saturates at DEPTH.

Decomposition:
- type_pkg additions:
  - burst_size_t (existing ONE_BYTE/TWO_BYTES/FOUR_BYTES/EIGHT_BYTES); encoding extended with SIXTEEN_BYTES for DATA_SIZE 128.
  - Function burst_bytes(burst_size_t) returning 1<<size.
  - Typedef raw_entry_t {valid, line, mask, data} parameterised via module localparams.
- One sub-module: byte_rotator (parametrised NBYTES, rotate right by COL_BITS amount, with byte-select mask). Used once for read extraction; write placement reuses it in rotate-left mode.

Test Plan:
- Write 0x10 EIGHT_BYTES 0x8877665544332211; read 0x13 FOUR_BYTES -> next cycle data 0x0000000077665544, mask 0x0F, hit 1.
- Write 0x20 TWO_BYTES 0xBBAA, then 0x22 TWO_BYTES 0xDDCC; read 0x20 FOUR_BYTES -> 0xDDCCBBAA, mask 0x0F, hit 1, occupancy 1. Read 0x20 EIGHT_BYTES -> mask 0x0F, hit 0.
- Write 0x0E EIGHT_BYTES 0x0807060504030201 (col 6, wraps); read 0x08 TWO_BYTES -> 0x0403, hit 1. Read of line 0 at 0x00 -> hit 0, mask 0.
- DEPTH=4: write lines 0x00, 0x08, 0x10, 0x18, then 0x20 -> occupancy 4, read 0x00 misses, read 0x08 hits.
- Hold rd_resp_ready low 3 cycles with a response pending -> data/mask constant, rd_req_ready 0. Raise ready with a new request valid -> both accepted that cycle, new response next cycle.
- Same-cycle write 0x30 ONE_BYTE 0x5A and read 0x30 ONE_BYTE -> data 0x5A, hit 1. flush+write 0x40 same cycle -> occupancy 1. rst asserted with response pending -> rd_resp_valid 0 next cycle, occupancy 0.
